// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register for the 16-bit 5-stage core: captures execute results and
// memory/writeback control, with stall, flush, sticky dump-halt and a retired-instruction counter.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] AluResIn,
  input  logic [15:0] RtIn,
  input  logic [2:0]  RdAddrIn,
  input  logic        RegWriteIn,
  input  logic        DMemWriteIn,
  input  logic        DMemEnIn,
  input  logic        MemToRegIn,
  input  logic        DMemDumpIn,
  input  logic        ValidIn,
  input  logic        Stall,
  input  logic        Flush,
  output logic [15:0] AluRes,
  output logic [15:0] RtOut,
  output logic [2:0]  RdAddrOut,
  output logic        RegWriteOut,
  output logic        DMemWriteOut,
  output logic        DMemEnOut,
  output logic        MemToRegOut,
  output logic        DMemDumpOut,
  output logic        ValidOut,
  output logic        FwdEn,
  output logic [2:0]  FwdAddr,
  output logic [15:0] FwdData,
  output logic        LoadPending,
  output logic        Halted,
  output logic [15:0] InstrCount
);

  logic [15:0] alu_res_q, alu_res_d;
  logic [15:0] rt_q, rt_d;
  logic [2:0]  rd_addr_q, rd_addr_d;
  logic        reg_write_q, reg_write_d;
  logic        dmem_write_q, dmem_write_d;
  logic        dmem_en_q, dmem_en_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        dmem_dump_q, dmem_dump_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] instr_count_q, instr_count_d;

  // Stall outranks Flush so an older stalled instruction is never killed.
  always_comb begin
    alu_res_d     = alu_res_q;
    rt_d          = rt_q;
    rd_addr_d     = rd_addr_q;
    reg_write_d   = reg_write_q;
    dmem_write_d  = dmem_write_q;
    dmem_en_d     = dmem_en_q;
    mem_to_reg_d  = mem_to_reg_q;
    dmem_dump_d   = dmem_dump_q;
    valid_d       = valid_q;
    halted_d      = halted_q;
    instr_count_d = instr_count_q;
    if (!Stall) begin
      if (Flush || halted_q) begin
        // Bubble: data fields keep their previous (don't-care) values.
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        dmem_write_d = 1'b0;
        dmem_en_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        dmem_dump_d  = 1'b0;
      end else begin
        alu_res_d    = AluResIn;
        rt_d         = RtIn;
        rd_addr_d    = RdAddrIn;
        valid_d      = ValidIn;
        reg_write_d  = RegWriteIn  & ValidIn;
        dmem_write_d = DMemWriteIn & ValidIn;
        dmem_en_d    = DMemEnIn    & ValidIn;
        mem_to_reg_d = MemToRegIn  & ValidIn;
        dmem_dump_d  = DMemDumpIn  & ValidIn;
        if (ValidIn && DMemDumpIn) begin
          halted_d = 1'b1;
        end
        if (ValidIn && (instr_count_q != 16'hFFFF)) begin
          instr_count_d = instr_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_res_q     <= 16'd0;
      rt_q          <= 16'd0;
      rd_addr_q     <= 3'd0;
      reg_write_q   <= 1'b0;
      dmem_write_q  <= 1'b0;
      dmem_en_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      dmem_dump_q   <= 1'b0;
      valid_q       <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= 16'd0;
    end else begin
      alu_res_q     <= alu_res_d;
      rt_q          <= rt_d;
      rd_addr_q     <= rd_addr_d;
      reg_write_q   <= reg_write_d;
      dmem_write_q  <= dmem_write_d;
      dmem_en_q     <= dmem_en_d;
      mem_to_reg_q  <= mem_to_reg_d;
      dmem_dump_q   <= dmem_dump_d;
      valid_q       <= valid_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign AluRes       = alu_res_q;
  assign RtOut        = rt_q;
  assign RdAddrOut    = rd_addr_q;
  assign RegWriteOut  = reg_write_q;
  assign DMemWriteOut = dmem_write_q;
  assign DMemEnOut    = dmem_en_q;
  assign MemToRegOut  = mem_to_reg_q;
  assign DMemDumpOut  = dmem_dump_q;
  assign ValidOut     = valid_q;
  assign Halted       = halted_q;
  assign InstrCount   = instr_count_q;

  // Hazard-unit outputs depend only on registered state.
  assign FwdEn       = valid_q & reg_write_q & ~mem_to_reg_q;
  assign FwdAddr     = rd_addr_q;
  assign FwdData     = alu_res_q;
  assign LoadPending = valid_q & reg_write_q & mem_to_reg_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic
// against a reference model of the capture/bubble/halt/count rules.
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic [15:0] AluResIn, RtIn;
  logic [2:0]  RdAddrIn;
  logic        RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn;
  logic        ValidIn, Stall, Flush;
  logic [15:0] AluRes, RtOut, FwdData, InstrCount;
  logic [2:0]  RdAddrOut, FwdAddr;
  logic        RegWriteOut, DMemWriteOut, DMemEnOut, MemToRegOut, DMemDumpOut;
  logic        ValidOut, FwdEn, LoadPending, Halted;

  ex_mem_reg dut (
    .clk(clk), .rst(rst),
    .AluResIn(AluResIn), .RtIn(RtIn), .RdAddrIn(RdAddrIn),
    .RegWriteIn(RegWriteIn), .DMemWriteIn(DMemWriteIn), .DMemEnIn(DMemEnIn),
    .MemToRegIn(MemToRegIn), .DMemDumpIn(DMemDumpIn), .ValidIn(ValidIn),
    .Stall(Stall), .Flush(Flush),
    .AluRes(AluRes), .RtOut(RtOut), .RdAddrOut(RdAddrOut),
    .RegWriteOut(RegWriteOut), .DMemWriteOut(DMemWriteOut), .DMemEnOut(DMemEnOut),
    .MemToRegOut(MemToRegOut), .DMemDumpOut(DMemDumpOut), .ValidOut(ValidOut),
    .FwdEn(FwdEn), .FwdAddr(FwdAddr), .FwdData(FwdData),
    .LoadPending(LoadPending), .Halted(Halted), .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference model state: what the memory stage should see.
  logic [15:0] m_alu, m_rt;
  logic [2:0]  m_rd;
  logic        m_valid, m_rw, m_mw, m_men, m_m2r, m_dump, m_halt;
  int          m_cnt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_alu = '0; m_rt = '0; m_rd = '0;
    m_valid = 0; m_rw = 0; m_mw = 0; m_men = 0; m_m2r = 0; m_dump = 0;
    m_halt = 0; m_cnt = 0;
  endtask

  // One clock edge of the pipeline register as a rule list.
  task automatic model_edge();
    if (Stall) return;
    if (Flush || m_halt) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_men = 0; m_m2r = 0; m_dump = 0;
      return;
    end
    m_alu = AluResIn; m_rt = RtIn; m_rd = RdAddrIn;
    m_valid = ValidIn;
    m_rw = ValidIn && RegWriteIn;
    m_mw = ValidIn && DMemWriteIn;
    m_men = ValidIn && DMemEnIn;
    m_m2r = ValidIn && MemToRegIn;
    m_dump = ValidIn && DMemDumpIn;
    if (ValidIn && DMemDumpIn) m_halt = 1;
    if (ValidIn) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {15'd0, ValidOut}, {15'd0, m_valid});
    chk({tag, ".ctrl"}, {11'd0, RegWriteOut, DMemWriteOut, DMemEnOut, MemToRegOut, DMemDumpOut},
        {11'd0, m_rw, m_mw, m_men, m_m2r, m_dump});
    chk({tag, ".alu"}, AluRes, m_alu);
    chk({tag, ".rt"}, RtOut, m_rt);
    chk({tag, ".rd"}, {13'd0, RdAddrOut}, {13'd0, m_rd});
    chk({tag, ".fwden"}, {15'd0, FwdEn}, {15'd0, m_valid & m_rw & ~m_m2r});
    chk({tag, ".fwdaddr"}, {13'd0, FwdAddr}, {13'd0, m_rd});
    chk({tag, ".fwddata"}, FwdData, m_alu);
    chk({tag, ".ldpend"}, {15'd0, LoadPending}, {15'd0, m_valid & m_rw & m_m2r});
    chk({tag, ".halted"}, {15'd0, Halted}, {15'd0, m_halt});
    chk({tag, ".count"}, InstrCount, m_cnt[15:0]);
  endtask

  task automatic set_in(input logic [15:0] alu, input logic [15:0] rt, input logic [2:0] rd,
                        input logic [4:0] ctrl, input logic v, input logic st, input logic fl);
    AluResIn = alu; RtIn = rt; RdAddrIn = rd;
    {RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn} = ctrl;
    ValidIn = v; Stall = st; Flush = fl;
  endtask

  task automatic rand_in(input int dump_pct);
    AluResIn = 16'($urandom); RtIn = 16'($urandom); RdAddrIn = 3'($urandom);
    RegWriteIn = 1'($urandom); DMemWriteIn = 1'($urandom); DMemEnIn = 1'($urandom);
    MemToRegIn = 1'($urandom);
    DMemDumpIn = ($urandom_range(99) < dump_pct);
    ValidIn = ($urandom_range(99) < 75);
    Stall = ($urandom_range(99) < 20);
    Flush = ($urandom_range(99) < 15);
  endtask

  // Inputs are set at negedge; apply one edge, then check at the next negedge.
  task automatic step(input string tag, input bit do_check);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (verbose)
      $display("[%0t] %s in v=%b st=%b fl=%b -> out v=%b alu=%h rd=%0d halt=%b cnt=%0d",
               $time, tag, ValidIn, Stall, Flush, ValidOut, AluRes, RdAddrOut, Halted, InstrCount);
    if (do_check) check_all(tag);
  endtask

  // Asserts rst a few ns after an edge, checks immediate clear, releases at negedge.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int c0;

  initial begin
    set_in('0, '0, '0, '0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    // Reset with toggling inputs: every output must stay 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_in(50);
      #1 check_all("in_reset");
    end
    @(negedge clk);
    rst = 1'b1;

    // Fill
    set_in(16'h1234, 16'hBEEF, 3'd5, 5'b10000, 1, 0, 0);
    step("fill", 1);
    chk("fill.fwden_lit", {15'd0, FwdEn}, 16'd1);
    chk("fill.count_lit", InstrCount, 16'd1);

    // Load-use then flush
    set_in(16'h0040, 16'h0001, 3'd2, 5'b10010, 1, 0, 0);
    step("load", 1);
    chk("load.ldpend_lit", {15'd0, LoadPending}, 16'd1);
    set_in(16'h9999, 16'h9999, 3'd7, 5'b11111, 1, 0, 1);
    step("load_flush", 1);
    chk("load_flush.ldpend_lit", {15'd0, LoadPending}, 16'd0);

    // Stall priority: A held three cycles (flush in the middle one), then B captured
    set_in(16'hAAAA, 16'h5555, 3'd3, 5'b11100, 1, 0, 0);
    step("stall_A", 1);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      set_in(16'hB0B0, 16'h0B0B, 3'd6, 5'b10000, 1, 1, (i == 1));
      step("stall_hold", 1);
      chk("stall_hold.alu_lit", AluRes, 16'hAAAA);
    end
    chk("stall.count_delta", InstrCount, 16'(c0));
    set_in(16'hB0B0, 16'h0B0B, 3'd6, 5'b10000, 1, 0, 0);
    step("stall_B", 1);
    chk("stall_B.alu_lit", AluRes, 16'hB0B0);

    // Invalid qualification
    c0 = m_cnt;
    set_in(16'h7777, 16'h8888, 3'd1, 5'b11111, 0, 0, 0);
    step("invalid", 1);
    chk("invalid.count_delta", InstrCount, 16'(c0));

    // Flushed dump is discarded
    set_in(16'h0D0D, 16'h0, 3'd0, 5'b00001, 1, 0, 1);
    step("dump_flushed", 1);
    chk("dump_flushed.halt_lit", {15'd0, Halted}, 16'd0);

    // Halt: dump once, then three valid instructions become bubbles
    c0 = m_cnt;
    set_in(16'hD000, 16'h0, 3'd0, 5'b00001, 1, 0, 0);
    step("dump", 1);
    chk("dump.dumpout_lit", {15'd0, DMemDumpOut}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(16'h1000 + 16'(i), 16'h0, 3'd4, 5'b10000, 1, 0, 0);
      step("post_halt", 1);
    end
    chk("halt.count_delta", InstrCount, 16'(c0 + 1));
    chk("halt.dumpout_cleared", {15'd0, DMemDumpOut}, 16'd0);

    // Randomized traffic with periodic asynchronous resets
    async_reset("rand_rst0");
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 49) async_reset("rand_rst");
      rand_in(4);
      step("rand", 1);
    end

    // Saturation
    async_reset("sat_rst");
    verbose = 1'b0;
    set_in(16'h5A5A, 16'hA5A5, 3'd1, 5'b10000, 1, 0, 0);
    for (int i = 0; i < 65534; i++) step("sat_fill", 0);
    verbose = 1'b1;
    chk("sat.fffe", InstrCount, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step("sat", 1);
      chk("sat.ffff_lit", InstrCount, 16'hFFFF);
    end
    async_reset("sat_async_rst");
    chk("sat.cleared_lit", InstrCount, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the execute stage and the memory stage of the 5-stage 16-bit core. It captures the execute result, the store data, the destination register and the memory/writeback control bits, and presents them to the memory stage one cycle later. It also supports stall (hold), flush (bubble insertion), a sticky halt after a dump instruction, and a saturating retired-instruction counter. Forwarding and load-use hazard outputs go to the hazard unit.

## Interface
- No parameters; data width fixed at 16, register address width fixed at 3.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately
- AluResIn  in  16  execute-stage result / memory address
- RtIn  in  16  store data from execute
- RdAddrIn  in  3  destination register
- RegWriteIn, DMemWriteIn, DMemEnIn, MemToRegIn, DMemDumpIn  in  1 each  control bits from execute
- ValidIn  in  1  execute slot holds a real instruction
- Stall  in  1  hold all contents this cycle
- Flush  in  1  load a bubble this cycle
- AluRes, RtOut  out  16 each  registered AluResIn, RtIn
- RdAddrOut  out  3  registered RdAddrIn
- RegWriteOut, DMemWriteOut, DMemEnOut, MemToRegOut, DMemDumpOut  out  1 each  registered control, valid-qualified
- ValidOut  out  1  register holds a real instruction
- FwdEn  out  1  ValidOut & RegWriteOut & ~MemToRegOut
- FwdAddr  out  3  equals RdAddrOut
- FwdData  out  16  equals AluRes
- LoadPending  out  1  ValidOut & RegWriteOut & MemToRegOut (load-use hazard indicator)
- Halted  out  1  sticky; a valid dump instruction has been captured
- InstrCount  out  16  number of valid instructions captured, saturating

## Operation
- Capture condition per edge, in priority order:
  - Stall=1: hold every register, including Halted and InstrCount. Flush is ignored.
  - Flush=1: load a bubble.
  - Halted=1: load a bubble. No instruction is accepted after a halt until reset.
  - Otherwise: capture all inputs; ValidOut <= ValidIn.
- Bubble: ValidOut and all five control outputs are 0. AluRes, RtOut and RdAddrOut are don't-care; the implementation holds their previous values.
- Valid qualification: when ValidIn=0 on a capture, the control outputs are stored as 0, whatever the input values.
- Halted is set on the edge that captures ValidIn=1 & DMemDumpIn=1. DMemDumpOut is 1 for that instruction only. Halted is cleared only by rst.
- InstrCount increments on each capture with ValidIn=1 and saturates at 16'hFFFF. Bubbles, stalls and flushes do not count.
- FwdEn, FwdAddr, FwdData and LoadPending are combinational from the registered state only. There is no path from the In ports to these outputs.

## Timing
- Latency: inputs present before edge N appear at the outputs after edge N (1 cycle).
- Reset: every output is 0 while rst=0, including AluRes, RtOut, RdAddrOut, Halted and InstrCount.
- Reset asserted mid-operation discards the held instruction. The first edge after rst deasserts captures normally.
- Stall held for k cycles: the outputs are stable for all k cycles. The first edge with Stall=0 performs a normal capture.
- Stall and Flush asserted in the same cycle: hold. The stalled instruction is older and must not be killed.
- Dump instruction captured while Flush=1: it is discarded and Halted stays 0.
- InstrCount at 16'hFFFF with another valid capture: stays at 16'hFFFF, with no wrap to 0.

## Test plan
- Reset and fill:
  - Stimulus: hold rst=0 with inputs toggling, then release; capture AluResIn=16'h1234, RtIn=16'hBEEF, RdAddrIn=3'd5, RegWriteIn=1, ValidIn=1.
  - Required: all outputs 0 during reset. Next cycle: AluRes=1234, RtOut=BEEF, RdAddrOut=5, FwdEn=1, FwdAddr=5, FwdData=1234, InstrCount=1.
- Load-use:
  - Stimulus: capture RegWriteIn=1, MemToRegIn=1, ValidIn=1.
  - Required: LoadPending=1 and FwdEn=0. After a following Flush edge, LoadPending=0 and ValidOut=0.
- Stall priority:
  - Stimulus: capture instruction A; assert Stall for 3 cycles, with Flush=1 in the 2nd cycle; present B as input throughout.
  - Required: A is held unchanged for 3 cycles and InstrCount does not change. B is captured on the first edge with Stall=0.
- Invalid qualification:
  - Stimulus: ValidIn=0 with all control inputs at 1.
  - Required: all control outputs 0, ValidOut=0, InstrCount unchanged.
- Halt:
  - Stimulus: capture a valid instruction with DMemDumpIn=1, then present 3 valid instructions.
  - Required: DMemDumpOut=1 for one cycle. Halted=1 stays set. The next 3 captures are bubbles and InstrCount rises by exactly 1. A flushed dump instruction leaves Halted=0.
- Saturation:
  - Stimulus: force InstrCount to 16'hFFFE via repeated captures (or a backdoor), then 3 valid captures.
  - Required: count reads FFFF and stays at FFFF. An async rst pulse mid-cycle clears it to 0 immediately.
